// File: rtl/smi_pkg.sv
// Shared constants for the SMI read-path controller: register map, CTRL/STATUS
// bit positions, version code, fetch FSM state type and lane-count helpers.
// No ports; imported by smi_stream_ctrl and smi_lfsr.
package smi_pkg;

  // Register map on the ioc/cs bus
  localparam logic [4:0] IOC_VERSION     = 5'd0;
  localparam logic [4:0] IOC_FIFO_STATUS = 5'd1;
  localparam logic [4:0] IOC_CTRL        = 5'd2;
  localparam logic [4:0] IOC_STATUS      = 5'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_TEST       = 1;
  localparam int CTRL_CHSEL_LSB  = 2;
  localparam int CTRL_CHSEL_MSB  = 3;
  localparam int CTRL_INTERLEAVE = 4;

  // STATUS bit positions
  localparam int STATUS_UNDERRUN = 0;

  localparam logic [7:0] SMI_VERSION = 8'h02;
  localparam logic [7:0] CTRL_RESET  = 8'h01;
  localparam logic [7:0] CTRL_MASK   = 8'h1F;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PULL  = 2'd1,
    ST_FULL  = 2'd2
  } fetch_state_e;

  // Number of SMI beats needed to send one FIFO word
  function automatic int smi_lanes(input int word_w, input int smi_w);
    return word_w / smi_w;
  endfunction

  // Index width for a counter over n items (at least 1 bit)
  function automatic int smi_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/smi_lfsr.sv
// Purpose: W-bit Fibonacci-style test pattern generator for the SMI read path.
// Latency: state_o shows the current pattern; a step or reload lands on the next clock.
// Backpressure: none; advances only when step_i is high.
// Ports: clk_i/rst_ni clock and async active-low reset, step_i advance,
//        reload_i force SEED (wins over step_i), state_o current pattern.
module smi_lfsr
  import smi_pkg::*;
#(
  parameter int             W    = 8,
  parameter logic [W-1:0]   SEED = 'h56,
  parameter logic [W-1:0]   TAPS = 'h0C
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         step_i,
  input  logic         reload_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;
  logic [W-1:0] shifted;

  // Feedback is the parity of the tapped bits, shifted in at the MSB.
  // The all-zero state would lock up, so it is replaced by the seed.
  assign shifted = {^(state_q & TAPS), state_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    if (reload_i) begin
      state_d = SEED;
    end else if (step_i) begin
      state_d = (shifted == '0) ? SEED : shifted;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/smi_stream_ctrl.sv
// Purpose: moves WORD_W-bit words from N_CH show-ahead RX FIFOs onto the SMI bus, MSB lane first.
// Latency: SOE falling edge at the pin -> o_smi_data_out updated 3 i_sys_clk later; pull -> word held next cycle.
// Backpressure: pops only into an empty holding register; a beat with nothing held outputs 0 and flags underrun.
// Ports: i_sys_clk/i_rst_b clock and async active-low reset; i_ioc/i_data_in/o_data_out/i_cs/
//        i_fetch_cmd/i_load_cmd register bus; o_fifo_pull/i_fifo_data/i_fifo_empty FIFO side;
//        i_smi_soe_se/o_smi_data_out/o_smi_read_req SMI side; o_underrun, o_address_error status.
module smi_stream_ctrl
  import smi_pkg::*;
#(
  parameter int               WORD_W    = 32,
  parameter int               SMI_W     = 8,
  parameter int               N_CH      = 2,
  parameter logic [SMI_W-1:0] TEST_SEED = 'h56,
  parameter logic [SMI_W-1:0] TEST_TAPS = 'h0C
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst_b,
  input  logic [4:0]               i_ioc,
  input  logic [7:0]               i_data_in,
  output logic [7:0]               o_data_out,
  input  logic                     i_cs,
  input  logic                     i_fetch_cmd,
  input  logic                     i_load_cmd,
  output logic [N_CH-1:0]          o_fifo_pull,
  input  logic [N_CH*WORD_W-1:0]   i_fifo_data,
  input  logic [N_CH-1:0]          i_fifo_empty,
  input  logic                     i_smi_soe_se,
  output logic [SMI_W-1:0]         o_smi_data_out,
  output logic                     o_smi_read_req,
  output logic                     o_underrun,
  output logic                     o_address_error
);

  localparam int LANES  = smi_lanes(WORD_W, SMI_W);
  localparam int LANE_W = smi_idx_w(LANES);
  localparam int CH_W   = smi_idx_w(N_CH);

  if ((WORD_W % SMI_W) != 0) begin : g_bad_word_w
    $error("WORD_W must be an integer multiple of SMI_W");
  end
  if ((N_CH < 1) || (N_CH > 4)) begin : g_bad_n_ch
    $error("N_CH must be in 1..4");
  end

  // ---------------------------------------------------------------- register file
  logic [7:0] ctrl_q;
  logic [7:0] data_out_q;
  logic [7:0] rd_data;
  logic       addr_err_q;
  logic       addr_err_d;
  logic       underrun_q;
  logic       underrun_d;
  logic       underrun_set;
  logic       wr_en, rd_en, ioc_mapped, chsel_bad, ctrl_wr;
  logic       test_chg, test_on;

  logic            en, test, interleave;
  logic [CH_W-1:0] ch_sel;

  assign en         = ctrl_q[CTRL_ENABLE];
  assign test       = ctrl_q[CTRL_TEST];
  assign interleave = ctrl_q[CTRL_INTERLEAVE];
  assign ch_sel     = ctrl_q[CTRL_CHSEL_LSB +: CH_W];

  assign wr_en      = i_cs & i_load_cmd;
  assign rd_en      = i_cs & i_fetch_cmd;
  assign ioc_mapped = (i_ioc <= IOC_STATUS);
  // Selecting a channel that does not exist is treated like a bad address.
  assign chsel_bad  = (i_ioc == IOC_CTRL) &&
                      (int'(i_data_in[CTRL_CHSEL_MSB:CTRL_CHSEL_LSB]) >= N_CH);
  assign ctrl_wr    = wr_en & (i_ioc == IOC_CTRL) & ~chsel_bad;
  assign test_chg   = ctrl_wr & (i_data_in[CTRL_TEST] != test);
  assign test_on    = ctrl_wr & i_data_in[CTRL_TEST] & ~test;

  assign addr_err_d = ((rd_en | wr_en) & ~ioc_mapped) | (wr_en & chsel_bad);

  // Reads sample the registers before any same-cycle write lands.
  always_comb begin
    rd_data = '0;
    case (i_ioc)
      IOC_VERSION:     rd_data = SMI_VERSION;
      IOC_FIFO_STATUS: rd_data = 8'(i_fifo_empty);
      IOC_CTRL:        rd_data = ctrl_q;
      IOC_STATUS:      rd_data = {7'b0, underrun_q};
      default:         rd_data = '0;
    endcase
  end

  // A new underrun in the same cycle as a clear wins, so no event is lost.
  always_comb begin
    underrun_d = underrun_q;
    if (wr_en && (i_ioc == IOC_STATUS) && i_data_in[STATUS_UNDERRUN]) begin
      underrun_d = 1'b0;
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      ctrl_q     <= CTRL_RESET;
      data_out_q <= '0;
      addr_err_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
      underrun_q <= underrun_d;
      if (rd_en) begin
        data_out_q <= rd_data;
      end
      if (ctrl_wr) begin
        ctrl_q <= i_data_in & CTRL_MASK;
      end
    end
  end

  // ---------------------------------------------------------------- SOE sync
  logic soe_meta_q, soe_sync_q, soe_prev_q;
  logic beat;

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      soe_meta_q <= 1'b0;
      soe_sync_q <= 1'b0;
      soe_prev_q <= 1'b0;
    end else begin
      soe_meta_q <= i_smi_soe_se;
      soe_sync_q <= soe_meta_q;
      soe_prev_q <= soe_sync_q;
    end
  end

  assign beat = soe_prev_q & ~soe_sync_q;

  // ---------------------------------------------------------------- LFSR
  logic [SMI_W-1:0] lfsr_state;
  logic             lfsr_step;

  smi_lfsr #(
    .W    (SMI_W),
    .SEED (TEST_SEED),
    .TAPS (TEST_TAPS)
  ) u_lfsr (
    .clk_i    (i_sys_clk),
    .rst_ni   (i_rst_b),
    .step_i   (lfsr_step),
    .reload_i (test_on),
    .state_o  (lfsr_state)
  );

  // ---------------------------------------------------------------- fetch FSM
  fetch_state_e     state_q;
  logic [N_CH-1:0]  pull_q;
  logic [WORD_W-1:0] holding_q;
  logic [LANE_W-1:0] lane_q;
  logic [CH_W-1:0]  cur_q;
  logic [CH_W-1:0]  pick_ch;
  logic [CH_W-1:0]  next_ch;
  logic [SMI_W-1:0] smi_q;
  logic [SMI_W-1:0] smi_d;
  logic             read_req_q;
  logic [WORD_W-1:0] fifo_head;
  logic [SMI_W-1:0] lane_word;

  // Outside interleave the channel is re-read from CTRL only while idle,
  // so a ch_sel write never splits a word that is already in flight.
  assign pick_ch   = interleave ? cur_q : ch_sel;
  assign next_ch   = (int'(cur_q) == N_CH - 1) ? '0 : cur_q + 1'b1;
  assign fifo_head = i_fifo_data[int'(cur_q)*WORD_W +: WORD_W];
  assign lane_word = holding_q[(LANES - 1 - int'(lane_q))*SMI_W +: SMI_W];

  always_comb begin
    smi_d        = smi_q;
    underrun_set = 1'b0;
    lfsr_step    = 1'b0;
    if (beat) begin
      if (!en) begin
        smi_d = '0;
      end else if (test) begin
        smi_d     = lfsr_state;
        lfsr_step = 1'b1;
      end else if (state_q == ST_FULL) begin
        smi_d = lane_word;
      end else begin
        smi_d        = '0;
        underrun_set = 1'b1;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= ST_EMPTY;
      pull_q     <= '0;
      holding_q  <= '0;
      lane_q     <= '0;
      cur_q      <= '0;
      smi_q      <= '0;
      read_req_q <= 1'b0;
    end else begin
      smi_q      <= smi_d;
      read_req_q <= en & (test | (state_q == ST_FULL));
      pull_q     <= '0;
      if (!en) begin
        state_q <= ST_EMPTY;
        lane_q  <= '0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            cur_q <= pick_ch;
            if (!test && !i_fifo_empty[pick_ch]) begin
              pull_q[pick_ch] <= 1'b1;
              state_q         <= ST_PULL;
            end
          end
          // Pop is visible to the FIFO this cycle; the show-ahead head is
          // still the popped word, so capture it now.
          ST_PULL: begin
            holding_q <= fifo_head;
            state_q   <= ST_FULL;
          end
          ST_FULL: begin
            if (beat && !test) begin
              if (int'(lane_q) == LANES - 1) begin
                lane_q  <= '0;
                state_q <= ST_EMPTY;
                if (interleave) begin
                  cur_q <= next_ch;
                end
              end else begin
                lane_q <= lane_q + 1'b1;
              end
            end
          end
          default: state_q <= ST_EMPTY;
        endcase
        if (test_chg) begin
          lane_q <= '0;
        end
      end
    end
  end

  assign o_data_out      = data_out_q;
  assign o_fifo_pull     = pull_q;
  assign o_smi_data_out  = smi_q;
  assign o_smi_read_req  = read_req_q;
  assign o_underrun      = underrun_q;
  assign o_address_error = addr_err_q;

endmodule

// File: tb/tb_smi_stream_ctrl.sv
// Purpose: directed self-checking bench for smi_stream_ctrl (defaults: 32-bit words, 8-bit SMI, 2 channels).
// Latency: SOE beats are 4 clocks low / 4 clocks high; outputs sampled on the falling clock edge.
// Backpressure: a small two-channel FIFO model answers o_fifo_pull pops.
module tb_smi_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [4:0]  ioc;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        cs, fetch_cmd, load_cmd;
  logic [1:0]  fifo_pull;
  logic [63:0] fifo_data;
  logic [1:0]  fifo_empty;
  logic        soe;
  logic [7:0]  smi_data;
  logic        read_req, underrun, addr_err;

  int checks   = 0;
  int failures = 0;

  // FIFO model: depth 8 per channel, show-ahead head word.
  logic [31:0] mem0 [8];
  logic [31:0] mem1 [8];
  logic [2:0]  fwr0 = 3'd0, fwr1 = 3'd0;
  logic [2:0]  frd0 = 3'd0, frd1 = 3'd0;
  int          pulls0 = 0, pulls1 = 0;

  assign fifo_data  = {mem1[frd1], mem0[frd0]};
  assign fifo_empty = {(frd1 == fwr1), (frd0 == fwr0)};

  always @(posedge clk) begin
    if (fifo_pull[0]) begin
      frd0   <= frd0 + 3'd1;
      pulls0 <= pulls0 + 1;
    end
    if (fifo_pull[1]) begin
      frd1   <= frd1 + 3'd1;
      pulls1 <= pulls1 + 1;
    end
  end

  always #5 clk = ~clk;

  smi_stream_ctrl dut (
    .i_sys_clk       (clk),
    .i_rst_b         (rst_b),
    .i_ioc           (ioc),
    .i_data_in       (data_in),
    .o_data_out      (data_out),
    .i_cs            (cs),
    .i_fetch_cmd     (fetch_cmd),
    .i_load_cmd      (load_cmd),
    .o_fifo_pull     (fifo_pull),
    .i_fifo_data     (fifo_data),
    .i_fifo_empty    (fifo_empty),
    .i_smi_soe_se    (soe),
    .o_smi_data_out  (smi_data),
    .o_smi_read_req  (read_req),
    .o_underrun      (underrun),
    .o_address_error (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic push(input int ch, input logic [31:0] w);
    if (ch == 0) begin
      mem0[fwr0] = w;
      fwr0 = fwr0 + 3'd1;
    end else begin
      mem1[fwr1] = w;
      fwr1 = fwr1 + 3'd1;
    end
  endtask

  // One bus cycle; returns on the falling edge after the capturing rising edge.
  task automatic reg_access(input logic [4:0] a, input logic [7:0] d, input logic ld, input logic ft);
    @(negedge clk);
    ioc = a; data_in = d; cs = 1'b1; load_cmd = ld; fetch_cmd = ft;
    @(negedge clk);
    cs = 1'b0; load_cmd = 1'b0; fetch_cmd = 1'b0;
  endtask

  task automatic soe_beat();
    @(negedge clk);
    soe = 1'b0;
    repeat (4) @(negedge clk);
    soe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      soe_beat();
      b = 8'(w >> (24 - 8 * i));
      check($sformatf("%s_b%0d", tag, i), {24'd0, smi_data}, {24'd0, b});
    end
  endtask

  initial begin
    rst_b = 1'b0; ioc = '0; data_in = '0; cs = 1'b0; fetch_cmd = 1'b0; load_cmd = 1'b0; soe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'd0, data_out}, 32'h0);
    check("rst_pull", {30'd0, fifo_pull}, 32'h0);
    check("rst_smi", {24'd0, smi_data}, 32'h0);
    check("rst_flags", {29'd0, read_req, underrun, addr_err}, 32'h0);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Register file
    reg_access(5'd2, 8'h00, 1'b0, 1'b1);
    check("ctrl_reset", {24'd0, data_out}, 32'h01);
    reg_access(5'd2, 8'h00, 1'b1, 1'b0);                 // disable
    push(0, 32'hA1B2C3D4);
    reg_access(5'd1, 8'h00, 1'b0, 1'b1);
    check("fifo_status", {24'd0, data_out}, 32'h02);
    reg_access(5'd0, 8'h00, 1'b0, 1'b1);
    check("version", {24'd0, data_out}, 32'h02);
    reg_access(5'd9, 8'h00, 1'b0, 1'b1);
    check("bad_ioc_pulse", {31'd0, addr_err}, 32'h1);
    check("bad_ioc_data", {24'd0, data_out}, 32'h0);
    @(negedge clk);
    check("bad_ioc_end", {31'd0, addr_err}, 32'h0);
    reg_access(5'd2, 8'h09, 1'b1, 1'b0);                 // ch_sel=2 does not exist
    check("bad_chsel_pulse", {31'd0, addr_err}, 32'h1);
    reg_access(5'd0, 8'h00, 1'b0, 1'b1);                 // data_out <= 02
    reg_access(5'd2, 8'h01, 1'b1, 1'b1);                 // write+read same cycle
    check("rd_before_wr", {24'd0, data_out}, 32'h00);
    check("disabled_no_pull", pulls0, 0);

    // Single-channel word
    repeat (5) @(negedge clk);
    check("pull_once", pulls0, 1);
    check("read_req_up", {31'd0, read_req}, 32'h1);
    expect_word("w0", 32'hA1B2C3D4);
    repeat (3) @(negedge clk);
    check("read_req_down", {31'd0, read_req}, 32'h0);
    check("pull_still_once", pulls0, 1);
    check("no_pull_ch1", pulls1, 0);
    check("no_underrun", {31'd0, underrun}, 32'h0);

    // Interleave
    reg_access(5'd2, 8'h11, 1'b1, 1'b0);
    push(0, 32'h11223344);
    push(1, 32'h55667788);
    repeat (5) @(negedge clk);
    expect_word("il_ch0", 32'h11223344);
    expect_word("il_ch1", 32'h55667788);
    push(0, 32'hAABBCCDD);
    repeat (5) @(negedge clk);
    expect_word("il_ch0b", 32'hAABBCCDD);
    push(0, 32'h01020304);                               // ch1 is next and empty
    repeat (5) @(negedge clk);
    soe_beat();
    check("stall_data", {24'd0, smi_data}, 32'h0);
    check("stall_underrun", {31'd0, underrun}, 32'h1);
    check("stall_no_skip", pulls0, 3);
    reg_access(5'd3, 8'h01, 1'b1, 1'b0);
    check("stall_clear", {31'd0, underrun}, 32'h0);
    push(1, 32'h9900AA55);
    repeat (5) @(negedge clk);
    expect_word("il_ch1b", 32'h9900AA55);
    repeat (5) @(negedge clk);
    expect_word("il_resume", 32'h01020304);
    check("il_pulls", pulls0 * 16 + pulls1, 4 * 16 + 2);

    // Underrun with all FIFOs empty
    reg_access(5'd2, 8'h01, 1'b1, 1'b0);
    soe_beat();
    check("ur_data", {24'd0, smi_data}, 32'h0);
    check("ur_flag", {31'd0, underrun}, 32'h1);
    reg_access(5'd3, 8'h00, 1'b1, 1'b0);
    check("ur_write0_keeps", {31'd0, underrun}, 32'h1);
    reg_access(5'd3, 8'h00, 1'b0, 1'b1);
    check("ur_status_rd", {24'd0, data_out}, 32'h01);
    reg_access(5'd3, 8'h01, 1'b1, 1'b0);
    check("ur_cleared", {31'd0, underrun}, 32'h0);

    // Test mode
    reg_access(5'd2, 8'h03, 1'b1, 1'b0);
    push(0, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    check("test_read_req", {31'd0, read_req}, 32'h1);
    soe_beat();
    check("lfsr0", {24'd0, smi_data}, 32'h56);
    soe_beat();
    check("lfsr1", {24'd0, smi_data}, 32'hAB);
    soe_beat();
    check("lfsr2", {24'd0, smi_data}, 32'hD5);
    check("test_no_pull", pulls0, 4);
    check("test_no_underrun", {31'd0, underrun}, 32'h0);

    // Disabled: beats output zero without underrun
    reg_access(5'd2, 8'h00, 1'b1, 1'b0);
    soe_beat();
    check("dis_data", {24'd0, smi_data}, 32'h0);
    check("dis_no_underrun", {31'd0, underrun}, 32'h0);
    check("dis_read_req", {31'd0, read_req}, 32'h0);

    // Reset mid-word
    reg_access(5'd2, 8'h01, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_rst_pull", pulls0, 5);
    soe_beat();
    check("mw_b0", {24'd0, smi_data}, 32'hCA);
    soe_beat();
    check("mw_b1", {24'd0, smi_data}, 32'hFE);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("mw_rst_outs", {data_out, smi_data, 6'd0, fifo_pull, 5'd0, read_req, underrun, addr_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    push(0, 32'h13579BDF);
    repeat (5) @(negedge clk);
    soe_beat();
    check("post_rst_msb", {24'd0, smi_data}, 32'h13);
    soe_beat();
    check("post_rst_b1", {24'd0, smi_data}, 32'h57);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
